// File: rtl/gpu_fb_arbiter.sv
// Framebuffer line-fetch / CPU arbiter sharing one memory port; fetched lines are double-buffered.
// Optional feature macro: GPU_FB_PIXEL_DOUBLING_EN (320-pixel lines fetched from a 240-line buffer).
module gpu_fb_arbiter #(
    parameter logic [14:0] FB_BASE = 15'h0000
`ifdef GPU_FB_PIXEL_DOUBLING_EN
    , localparam int N = 320
    , localparam int W = 10
    , localparam int H = 240
`else
    , localparam int N = 640
    , localparam int W = 20
    , localparam int H = 480
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          refill,
    input  logic [9:0]    line,
    input  logic          cpu_valid,
    input  logic [14:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wstrb,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_ready,
    output logic          mem_valid,
    output logic [14:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready,
    output logic [N-1:0]  hline_r,
    output logic [N-1:0]  hline_g,
    output logic [N-1:0]  hline_b,
    output logic          busy,
    output logic          overrun
);

    localparam logic [31:0] PLANE_WORDS = 32'(W * H);
    localparam logic [31:0] LINE_WORDS  = 32'(W);

    typedef enum logic [1:0] {IDLE, CPU, FETCH, COMMIT} state_t;

    state_t         state_q, state_d;
    logic           pending_q, busy_q, overrun_q, mem_valid_q;
    logic [9:0]     line_q;
    logic [1:0]     plane_q;
    logic [4:0]     k_q;
    logic [14:0]    mem_addr_q;
    logic [31:0]    mem_wdata_q;
    logic [3:0]     mem_wstrb_q;
    logic [N-1:0]   back_r_q, back_g_q, back_b_q;
    logic [N-1:0]   hline_r_q, hline_g_q, hline_b_q;

    logic           done, last_word, fetch_start, refill_drop, refill_hold, issue;
    logic [9:0]     line_eff;
    logic [14:0]    fetch_addr;

    function automatic logic [9:0] fetch_line(input logic [9:0] l);
`ifdef GPU_FB_PIXEL_DOUBLING_EN
        return {1'b0, l[9:1]};
`else
        return l;
`endif
    endfunction

    always_comb begin
        done        = mem_valid_q && mem_ready && !reset;
        last_word   = (plane_q == 2'd2) && (k_q == 5'(W - 1));
        // A refill seen in IDLE starts the fetch immediately, so it beats cpu_valid.
        fetch_start = (state_q == IDLE) && (pending_q || refill);
        refill_drop = refill && (busy_q || pending_q);
        refill_hold = refill && !busy_q && !pending_q && !fetch_start;
        issue       = ((state_q == CPU) || (state_q == FETCH)) && !mem_valid_q;
        line_eff    = pending_q ? line_q : fetch_line(line);
        fetch_addr  = 15'(32'(FB_BASE) + 32'(plane_q) * PLANE_WORDS
                          + 32'(line_q) * LINE_WORDS + 32'(k_q));
        state_d     = state_q;
        case (state_q)
            IDLE:    if (fetch_start) state_d = FETCH;
                     else if (cpu_valid) state_d = CPU;
            CPU:     if (done) state_d = busy_q ? FETCH : IDLE;
            FETCH:   if (done) begin
                         if (last_word) state_d = COMMIT;
                         else if (cpu_valid) state_d = CPU;
                     end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            line_q      <= '0;
            plane_q     <= '0;
            k_q         <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            back_r_q    <= '0;
            back_g_q    <= '0;
            back_b_q    <= '0;
            hline_r_q   <= '0;
            hline_g_q   <= '0;
            hline_b_q   <= '0;
        end else begin
            if (issue) begin
                mem_valid_q <= 1'b1;
                if (state_q == CPU) begin
                    mem_addr_q  <= cpu_addr;
                    mem_wdata_q <= cpu_wdata;
                    mem_wstrb_q <= cpu_wstrb;
                end else begin
                    mem_addr_q  <= fetch_addr;
                    mem_wdata_q <= '0;
                    mem_wstrb_q <= '0;
                end
            end
            if (done) mem_valid_q <= 1'b0;
            if (done && (state_q == FETCH)) begin
                case (plane_q)
                    2'd0:    back_r_q[{k_q, 5'd0} +: 32] <= mem_rdata;
                    2'd1:    back_g_q[{k_q, 5'd0} +: 32] <= mem_rdata;
                    default: back_b_q[{k_q, 5'd0} +: 32] <= mem_rdata;
                endcase
                if (k_q == 5'(W - 1)) begin
                    k_q     <= '0;
                    plane_q <= plane_q + 2'd1;
                end else begin
                    k_q <= k_q + 5'd1;
                end
            end
            if (fetch_start) begin
                pending_q <= 1'b0;
                busy_q    <= 1'b1;
                plane_q   <= '0;
                k_q       <= '0;
                line_q    <= line_eff;
            end else if (refill_hold) begin
                pending_q <= 1'b1;
                line_q    <= fetch_line(line);
            end
            if (refill_drop) overrun_q <= 1'b1;
            // Single-cycle copy keeps the display from ever seeing a half-fetched line.
            if (state_q == COMMIT) begin
                hline_r_q <= back_r_q;
                hline_g_q <= back_g_q;
                hline_b_q <= back_b_q;
                busy_q    <= 1'b0;
            end
        end
    end

    assign cpu_ready = (state_q == CPU) && done;
    assign cpu_rdata = cpu_ready ? mem_rdata : 32'd0;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign hline_r   = hline_r_q;
    assign hline_g   = hline_g_q;
    assign hline_b   = hline_b_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_gpu_fb_arbiter.sv
// Randomized bench for gpu_fb_arbiter: memory responder, CPU traffic generator and a
// transaction-log reference model of line fetch order, fairness and committed planes.
module tb_gpu_fb_arbiter;
`ifdef GPU_FB_PIXEL_DOUBLING_EN
    localparam int N = 320;
    localparam int W = 10;
    localparam int H = 240;
`else
    localparam int N = 640;
    localparam int W = 20;
    localparam int H = 480;
`endif
    localparam int FB_BASE = 0;
    localparam int CPU_LO  = 28800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          refill = 1'b0;
    logic [9:0]    line = '0;
    logic          cpu_valid = 1'b0;
    logic [14:0]   cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [3:0]    cpu_wstrb = '0;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready;
    logic          mem_valid;
    logic [14:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [N-1:0]  hline_r, hline_g, hline_b;
    logic          busy, overrun;

    gpu_fb_arbiter #(.FB_BASE(15'(FB_BASE))) dut (
        .clk(clk), .reset(reset), .refill(refill), .line(line),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hline_r(hline_r), .hline_g(hline_g), .hline_b(hline_b),
        .busy(busy), .overrun(overrun)
    );

    // Controls owned by the sequencing initial block.
    int         refill_req = 0, force_req = 0, late_req = 0;
    logic [9:0] refill_line_v = '0;
    logic       cpu_en = 1'b0, cpu_always = 1'b0, data_mode = 1'b0;
    int         dmin = 0, dmax = 0;

    // State owned by the negedge stimulus/monitor block.
    logic [14:0] lg_addr[$];
    logic [31:0] lg_wdata[$];
    logic [3:0]  lg_wstrb[$];
    logic        lg_cv[$], lg_busy[$];
    logic [14:0] cq_addr[$];
    logic [31:0] cq_wdata[$];
    logic [3:0]  cq_wstrb[$];
    int          refill_ack = 0, force_ack = 0, late_ack = 0;
    int          rd_err = 0, addr_err = 0, spurious = 0, cpu_done = 0, commit_cnt = 0;
    int          wcnt = 0, wdelay = 0;
    logic        waiting = 1'b0, logged = 1'b0;
    logic [14:0] hold_addr = '0;
    logic [N-1:0] prev_hr = '0;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [14:0] a);
        if (data_mode == 1'b0) return {17'd0, a};
        return {a, 2'b10, ~a};
    endfunction

    function automatic int lfun(input int l);
`ifdef GPU_FB_PIXEL_DOUBLING_EN
        return l / 2;
`else
        return l;
`endif
    endfunction

    function automatic logic [14:0] exp_addr(input int lf, input int idx);
        int v;
        v = FB_BASE + (idx / W) * W * H + lf * W + (idx % W);
        return 15'(v % 32768);
    endfunction

    function automatic logic [N-1:0] exp_plane(input int lf, input int p);
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < W; k++) v[32*k +: 32] = memf(exp_addr(lf, p * W + k));
        return v;
    endfunction

    always @(negedge clk) begin
        logged = 1'b0;
        if (mem_ready) mem_ready = 1'b0;
        else if (late_req != late_ack) begin
            mem_ready = 1'b1;
            mem_rdata = $urandom;
            late_ack++;
            waiting = 1'b0;
        end else if (mem_valid) begin
            if (!waiting) begin
                waiting = 1'b1;
                wcnt = 0;
                wdelay = $urandom_range(dmax, dmin);
                hold_addr = mem_addr;
            end else if (mem_addr != hold_addr) addr_err++;
            if (wcnt >= wdelay) begin
                mem_ready = 1'b1;
                mem_rdata = memf(mem_addr);
                waiting = 1'b0;
                logged = 1'b1;
            end else wcnt++;
        end else waiting = 1'b0;
        #1;
        if (hline_r != prev_hr) begin
            commit_cnt++;
            prev_hr = hline_r;
        end
        if (cpu_ready) begin
            if (!cpu_valid) spurious++;
            else begin
                if (cpu_wstrb == 4'd0 && cpu_rdata != memf(cpu_addr)) rd_err++;
                cpu_done++;
                cpu_valid = 1'b0;
            end
        end
        if (refill) refill = 1'b0;
        if (refill_req != refill_ack) begin
            refill = 1'b1;
            line = refill_line_v;
            refill_ack++;
        end
        if (!cpu_valid && (force_req != force_ack || cpu_always ||
                           (cpu_en && $urandom_range(2, 0) == 0))) begin
            if (force_req != force_ack) force_ack++;
            cpu_addr  = 15'(CPU_LO + $urandom_range(32767 - CPU_LO, 0));
            cpu_wstrb = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 0)) : 4'd0;
            cpu_wdata = $urandom;
            cpu_valid = 1'b1;
            cq_addr.push_back(cpu_addr);
            cq_wdata.push_back(cpu_wdata);
            cq_wstrb.push_back(cpu_wstrb);
        end
        if (logged) begin
            lg_addr.push_back(mem_addr);
            lg_wdata.push_back(mem_wdata);
            lg_wstrb.push_back(mem_wstrb);
            lg_cv.push_back(cpu_valid);
            lg_busy.push_back(busy);
        end
    end

    task automatic wait_fetch(input string tag);
        bit started = 0, ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (busy) started = 1;
            else if (started) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_fetch_done"}, N'(ok), N'(1));
    endtask

    task automatic wait_cpu_idle(input string tag);
        bit ok = 0;
        cpu_en = 1'b0;
        cpu_always = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (!cpu_valid && force_req == force_ack) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_cpu_idle"}, N'(ok), N'(1));
    endtask

    task automatic verify(input string tag, input int lb, input int cb, input int lf);
        int fi = 0, ci = cb, seq_err = 0, fair_err = 0, busy_err = 0, cpu_err = 0, need = 0;
        for (int i = lb; i < lg_addr.size(); i++) begin
            if (int'(lg_addr[i]) < CPU_LO) begin
                if (need == 1) fair_err++;
                if (fi >= 3 * W || lg_addr[i] != exp_addr(lf, fi) || lg_wstrb[i] != 4'd0) seq_err++;
                if (!lg_busy[i]) busy_err++;
                fi++;
                need = (fi < 3 * W) ? (lg_cv[i] ? 1 : 2) : 0;
            end else begin
                if (need == 2) fair_err++;
                if (need == 1 && !lg_busy[i]) busy_err++;
                if (ci >= cq_addr.size() || lg_addr[i] != cq_addr[ci] ||
                    lg_wdata[i] != cq_wdata[ci] || lg_wstrb[i] != cq_wstrb[ci]) cpu_err++;
                ci++;
                if (need == 1) need = 2;
            end
        end
        check({tag, "_nfetch"}, N'(fi), N'(3 * W));
        check({tag, "_fetch_order"}, N'(seq_err), N'(0));
        check({tag, "_fairness"}, N'(fair_err), N'(0));
        check({tag, "_busy"}, N'(busy_err), N'(0));
        check({tag, "_cpu_txn"}, N'(cpu_err), N'(0));
        check({tag, "_ncpu"}, N'(ci), N'(cq_addr.size()));
        check({tag, "_hline_r"}, hline_r, exp_plane(lf, 0));
        check({tag, "_hline_g"}, hline_g, exp_plane(lf, 1));
        check({tag, "_hline_b"}, hline_b, exp_plane(lf, 2));
    endtask

    task automatic random_line(input string tag, input bit always_cpu);
        int lb, cb, ln;
        ln = $urandom_range(479, 0);
        dmin = 0; dmax = 3; data_mode = 1'b1;
        lb = lg_addr.size(); cb = cq_addr.size();
        cpu_en = 1'b1; cpu_always = always_cpu;
        repeat ($urandom_range(6, 0)) begin @(posedge clk); #1; end
        refill_line_v = 10'(ln);
        refill_req++;
        wait_fetch(tag);
        wait_cpu_idle(tag);
        verify(tag, lb, cb, lfun(ln));
    endtask

    initial begin
        int lb, cb, cd, cc, sp;
        bit found;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", N'(busy), N'(0));
        check("rst_overrun", N'(overrun), N'(0));
        check("rst_mem_valid", N'(mem_valid), N'(0));
        check("rst_cpu_ready", N'(cpu_ready), N'(0));
        check("rst_mem_addr", N'({mem_addr, mem_wstrb, mem_wdata}), N'(0));
        check("rst_hline", hline_r | hline_g | hline_b, '0);

        // Line 2, address-as-data memory, immediate ready.
        data_mode = 1'b0; dmin = 0; dmax = 0;
        lb = lg_addr.size(); cb = cq_addr.size(); cc = commit_cnt;
        refill_line_v = 10'd2;
        refill_req++;
        wait_fetch("A");
        verify("A", lb, cb, lfun(2));
        check("A_word0", N'(hline_r[31:0]), N'(exp_addr(lfun(2), 0)));
        repeat (2) begin @(posedge clk); #1; end
        check("A_commits", N'(commit_cnt - cc), N'(1));

        // Refill and CPU request in the same IDLE cycle.
        data_mode = 1'b1; dmin = 0; dmax = 2;
        lb = lg_addr.size(); cb = cq_addr.size(); cd = cpu_done;
        refill_line_v = 10'd100;
        refill_req++;
        force_req++;
        wait_fetch("B");
        wait_cpu_idle("B");
        check("B_ntx", N'(lg_addr.size() - lb >= 2), N'(1));
        if (lg_addr.size() - lb >= 2) begin
            check("B_first_is_fetch", N'(lg_addr[lb]), N'(exp_addr(lfun(100), 0)));
            check("B_second_is_cpu", N'(lg_addr[lb + 1]), N'(cq_addr[cb]));
        end
        check("B_cpu_ready_once", N'(cpu_done - cd), N'(1));
        verify("B", lb, cb, lfun(100));

        random_line("ALT", 1'b1);
        for (int it = 0; it < 3; it++) random_line("RND", 1'b0);
        check("RND_overrun_clear", N'(overrun), N'(0));

        // Second refill during a fetch is dropped.
        dmin = 0; dmax = 1; cpu_en = 1'b0;
        lb = lg_addr.size(); cb = cq_addr.size(); cc = commit_cnt;
        refill_line_v = 10'd333;
        refill_req++;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (busy) begin found = 1; break; end
        end
        check("D_busy_seen", N'(found), N'(1));
        refill_line_v = 10'd77;
        refill_req++;
        wait_fetch("D");
        repeat (20) begin @(posedge clk); #1; end
        verify("D", lb, cb, lfun(333));
        check("D_overrun", N'(overrun), N'(1));
        check("D_commits", N'(commit_cnt - cc), N'(1));

        // Reset with fetch word 30 in flight, then a stray mem_ready.
        dmin = 3; dmax = 3;
        lb = lg_addr.size();
        refill_line_v = 10'd400;
        refill_req++;
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (lg_addr.size() - lb == 30 && mem_valid) begin found = 1; break; end
        end
        check("E_word30_reached", N'(found), N'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("E_hline_r", hline_r, '0);
        check("E_hline_gb", hline_g | hline_b, '0);
        check("E_busy", N'(busy), N'(0));
        check("E_mem_valid", N'(mem_valid), N'(0));
        check("E_overrun", N'(overrun), N'(0));
        cd = cpu_done; sp = spurious;
        late_req++;
        repeat (4) begin @(posedge clk); #1; end
        check("E_late_mem_valid", N'(mem_valid), N'(0));
        check("E_late_busy", N'(busy), N'(0));
        check("E_late_hline", hline_r | hline_g | hline_b, '0);
        check("E_late_cpu_ready", N'(cpu_done - cd + spurious - sp), N'(0));

        random_line("POST", 1'b0);

        check("cpu_rdata", N'(rd_err), N'(0));
        check("mem_addr_stable", N'(addr_err), N'(0));
        check("cpu_ready_spurious", N'(spurious), N'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/gpu_fb_arbiter.md
GPU_FB_ARBITER -- requirements
Module: gpu_fb_arbiter

Interface
REQ-001 Parameter: FB_BASE, 15'h0000, framebuffer base word address.
REQ-002 Clocking and reset SHALL be: one clock, clk; synchronous active-high reset, reset.
REQ-003 clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 refill  in  1  one-cycle pulse requesting a line fetch.
REQ-006 line  in  10  display line (0..479) to fetch, sampled on refill.
REQ-007 cpu_valid / cpu_addr / cpu_wdata / cpu_wstrb  in  1/15/32/4  CPU word access; wstrb==0 means read.
REQ-008 cpu_rdata / cpu_ready  out  32/1  CPU read data; one-cycle completion pulse.
REQ-009 mem_valid / mem_addr / mem_wdata / mem_wstrb  out  1/15/32/4  shared memory port.
REQ-010 mem_rdata / mem_ready  in  32/1  memory read data; one-cycle completion pulse.
REQ-011 hline_r / hline_g / hline_b  out  N each  committed line planes (N per Configuration).
REQ-012 busy / overrun  out  1/1  fetch in progress; sticky lost-refill flag.

Function
REQ-013 States SHALL be IDLE, CPU, FETCH, COMMIT.
REQ-014 A refill pulse SHALL set a pending flag and latch line; the fetch line index SHALL be L = line (no doubling) or line>>1 (doubling).
REQ-015 In IDLE with the pending flag set, the block SHALL enter FETCH; otherwise, with cpu_valid set, it SHALL enter CPU.
REQ-016 A pending fetch SHALL win over cpu_valid in the same cycle.
REQ-017 In CPU, the block SHALL drive mem_* from the cpu_* inputs and hold them stable until mem_ready.
REQ-018 On mem_ready in CPU, the block SHALL pulse cpu_ready and present cpu_rdata=mem_rdata in the same cycle, then return to IDLE.
REQ-019 A fetch SHALL issue 3*W reads with mem_wstrb=0, W words per plane, in order: plane r words 0..W-1, then g, then b.
REQ-020 Fetch word address SHALL be FB_BASE + p*W*H + L*W + k, where p is 0/1/2 and k is the word index, computed modulo 2^15.
REQ-021 Read word k of a plane SHALL be stored into back-buffer bits [32k+31:32k], with bit 0 at pixel 0.
REQ-022 mem_valid SHALL rise the cycle after entering CPU or FETCH and SHALL stay high, with address constant, until mem_ready.
REQ-023 Fairness: after each fetch word completes, if cpu_valid is high, exactly one CPU access SHALL be served (CPU, then back to FETCH) before the next fetch word.
REQ-024 After the last word, COMMIT SHALL copy all three back buffers to hline_* in one cycle, then go to IDLE.
REQ-025 hline_* SHALL change only in COMMIT, so the display never sees a partial line.
REQ-026 busy SHALL be high from FETCH entry through COMMIT, including interleaved CPU accesses.
REQ-027 A refill while busy=1 or while pending SHALL be dropped and SHALL set overrun; the in-progress fetch SHALL continue unchanged.
REQ-028 A refill arriving while in CPU with no fetch active SHALL become pending and start a fetch after cpu_ready.
REQ-029 overrun SHALL be cleared only by reset.

Reset
REQ-030 On reset: state=IDLE; pending, busy, overrun, mem_valid and cpu_ready = 0; mem_addr/wdata/wstrb = 0; hline_* and back buffers = 0.
REQ-031 Reset mid-transaction SHALL abandon it: no cpu_ready and no commit; a mem_ready arriving after reset SHALL be ignored.

Configuration
REQ-032 Macro GPU_FB_PIXEL_DOUBLING_EN.
REQ-033 With GPU_FB_PIXEL_DOUBLING_EN defined: N=320, W=10, H=240, L=line>>1.
REQ-034 Without GPU_FB_PIXEL_DOUBLING_EN: N=640, W=20, H=480, L=line.

Verification
REQ-035 No doubling, FB_BASE=0, refill with line=2, memory returns addr as data, 1-cycle ready -> 60 reads at 40..59, 9640..9659, 19240..19259; hline_r[31:0]=40; single commit.
REQ-036 cpu_valid and refill asserted in the same IDLE cycle -> fetch word 0 issued first, CPU access served after word 0, cpu_ready pulses once.
REQ-037 cpu_valid held high throughout a fetch -> strict alternation fetch/CPU; fetch completes after 60 fetch words.
REQ-038 Second refill during fetch -> overrun=1, exactly 60 reads, hline_* reflect the first line.
REQ-039 reset asserted at fetch word 30 -> hline_*=0, busy=0, mem_valid=0 next cycle; a late mem_ready is ignored.
REQ-040 Doubling build, refill with line=5 -> L=2, 30 reads at 20..29, 2420..2429, 4820..4829; N=320.
